alarm_ring_ctrl: RTL and testbench
==================================

Name: alarm_ring_ctrl

Overview:
- Sequences the alarm buzzer once the alarm time has been programmed.
- Detects the alarm-time match, then runs the ringing pattern with a timeout, a snooze with a limit on the number of snoozes, and stop/dismiss.
- Sits between the alarm-setting FSM (which supplies al_hr/al_min), the timekeeping counter (which supplies hr/min/sec_tick) and the buzzer driver.

Parameters:
- RING_SECS, 60, number of sec_tick pulses a ring session lasts before it auto-stops (≥2).
- SNOOZE_MIN, 9, snooze length in minutes; the snooze lasts SNOOZE_MIN*60 sec_tick pulses (1..1000).
- MAX_SNOOZE, 3, maximum number of snoozes per alarm event (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sec_tick  in  1  one-clk pulse, once per second, synchronous to clk.
- alarm_en  in  1  alarm armed (level).
- hr  in  8  current hour.
- min  in  8  current minute.
- al_hr  in  8  programmed alarm hour.
- al_min  in  8  programmed alarm minute.
- snooze_btn  in  1  snooze button, level, already debounced and synchronous.
- stop_btn  in  1  stop button, level, already debounced and synchronous.
- buzzer  out  1  buzzer drive, pulsed 1 s on / 1 s off while ringing.
- ringing  out  1  high in the RING state.
- snoozing  out  1  high in the SNOOZE state.
- snooze_cnt  out  4  snoozes used in the current alarm event.
- timed_out  out  1  one-clk pulse when a ring session ends by timeout.

Behaviour:
- Reset (async, rst=0) clears everything immediately, including mid-ring or mid-snooze:
  - state=IDLE; all outputs 0.
  - match_q, snooze_q, stop_q, beep and all counters = 0.
- Match and edge detection:
  - match = alarm_en & (hr==al_hr) & (min==al_min).
  - match_q, snooze_q and stop_q register match, snooze_btn and stop_btn every clk.
  - match_rise = match & ~match_q; snz_rise and stop_rise are formed the same way.
  - Only rising edges act. Holding a button does not repeat. Stopping during the matching minute does not re-trigger.
- States: IDLE, RING, SNOOZE (2-bit encoding). All transitions happen on the clk edge where their condition is true.
- alarm_en=0 in RING or SNOOZE: go to IDLE on the next clk; snooze_cnt=0. This has top priority.
- IDLE:
  - match_rise -> RING; ring_cnt=0; beep=1; snooze_cnt=0.
  - ringing is therefore 1 in the cycle after match first goes high.
- RING, priority stop > snooze > timeout:
  - stop_rise -> IDLE; snooze_cnt=0.
  - snz_rise with snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt+1; snz_cnt=0.
  - snz_rise with snooze_cnt==MAX_SNOOZE is ignored; the block stays in RING.
  - On sec_tick with ring_cnt==RING_SECS-1 -> IDLE; timed_out=1 for one clk; snooze_cnt=0.
  - On any other sec_tick: ring_cnt+1 and beep toggles.
  - A button edge in the same cycle as a sec_tick wins; the tick is discarded.
- SNOOZE:
  - stop_rise -> IDLE; snooze_cnt=0.
  - On sec_tick with snz_cnt==SNOOZE_MIN*60-1 -> RING; ring_cnt=0; beep=1.
  - On any other sec_tick: snz_cnt+1.
  - snz_rise and match_rise are ignored.
  - snooze_cnt holds its value across re-rings.
- Outputs:
  - buzzer = (state==RING) & beep, registered. Buzzer is 0 in IDLE and SNOOZE.
  - ringing and snoozing are decoded from the state register.
  - snooze_cnt saturates at MAX_SNOOZE.
- Widths:
  - ring_cnt is 8 bits and snz_cnt is 16 bits; both compare for equality only.
  - hr and min are compared raw; no range checking.

Test Plan:
- Use RING_SECS=4, SNOOZE_MIN=1, MAX_SNOOZE=2 and sec_tick every 10 clks unless stated otherwise.
- Match and timeout:
  - Stimulus: al_hr=7, al_min=30, alarm_en=1; hr/min step from 7:29 to 7:30.
  - Required: ringing=1 the next clk; buzzer follows 1,0,1,0 across the 4 ticks; timed_out pulses once; then IDLE. No re-ring while min stays at 30.
- Snooze limit:
  - Stimulus: snooze in RING, twice.
  - Required: snoozing=1 with snooze_cnt=1, then 2. Ringing resumes after exactly 60 ticks each time. A third snz_rise is ignored (ringing stays 1, snooze_cnt=2).
- Stop:
  - Stimulus: stop_rise in RING, and separately stop_rise in SNOOZE.
  - Required: IDLE next clk; buzzer=0; snooze_cnt=0. Holding stop_btn for 50 clks has no further effect.
- Priority:
  - Stimulus: stop_rise and snz_rise in the same cycle, coinciding with the final ring sec_tick.
  - Required: IDLE; timed_out stays 0; snooze_cnt=0.
- alarm_en and reset:
  - Stimulus: drop alarm_en mid-SNOOZE; separately, assert rst=0 mid-RING between clk edges.
  - Required: IDLE on the next clk for alarm_en. For rst, all outputs are 0 immediately without a clk edge.
- Disarmed:
  - Stimulus: match occurs while alarm_en=0.
  - Required: stays IDLE; buzzer is never asserted.

Source files
------------

// File: rtl/alarm_ring_ctrl.sv
// rtl/alarm_ring_ctrl.sv - alarm match detection, ring/snooze/stop sequencing and buzzer drive
//
// Purpose:
//   Watches the timekeeping counter against the programmed alarm time. On the
//   rising edge of a match it rings the buzzer (1 s on / 1 s off) for
//   RING_SECS seconds, supports up to MAX_SNOOZE snoozes of SNOOZE_MIN
//   minutes each, and can be stopped or disarmed at any point.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   sec_tick     one-clk pulse per second
//   alarm_en     alarm armed (level)
//   hr, min      current time
//   al_hr/al_min programmed alarm time
//   snooze_btn   snooze button (level, debounced, synchronous)
//   stop_btn     stop button (level, debounced, synchronous)
//   buzzer       buzzer drive, registered
//   ringing      high while in RING
//   snoozing     high while in SNOOZE
//   snooze_cnt   snoozes used in the current alarm event
//   timed_out    one-clk pulse when a ring session ends by timeout

module alarm_ring_ctrl #(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       alarm_en,
  input  logic [7:0] hr,
  input  logic [7:0] min,
  input  logic [7:0] al_hr,
  input  logic [7:0] al_min,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_cnt,
  output logic       timed_out
);

  localparam logic [7:0]  RING_LAST = 8'(RING_SECS - 1);
  localparam logic [15:0] SNZ_LAST  = 16'(SNOOZE_MIN * 60 - 1);
  localparam logic [3:0]  SNZ_MAX   = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        match_q;
  logic        snooze_q;
  logic        stop_q;
  logic        beep_q, beep_d;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
  logic [15:0] snz_cnt_q, snz_cnt_d;
  logic [3:0]  snooze_cnt_q, snooze_cnt_d;
  logic        timed_out_q, timed_out_d;
  logic        buzzer_q;

  logic match;
  logic match_rise;
  logic snz_rise;
  logic stop_rise;
  logic snz_ok;

  assign match      = alarm_en & (hr == al_hr) & (min == al_min);
  assign match_rise = match & ~match_q;
  assign snz_rise   = snooze_btn & ~snooze_q;
  assign stop_rise  = stop_btn & ~stop_q;

  // A snooze request once the limit is reached is treated as no request at
  // all, so a coincident sec_tick is still counted.
  assign snz_ok = snz_rise & (snooze_cnt_q < SNZ_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      match_q      <= 1'b0;
      snooze_q     <= 1'b0;
      stop_q       <= 1'b0;
      beep_q       <= 1'b0;
      ring_cnt_q   <= 8'd0;
      snz_cnt_q    <= 16'd0;
      snooze_cnt_q <= 4'd0;
      timed_out_q  <= 1'b0;
      buzzer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_q      <= match;
      snooze_q     <= snooze_btn;
      stop_q       <= stop_btn;
      beep_q       <= beep_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      timed_out_q  <= timed_out_d;
      // Built from next-state so the buzzer lines up with ringing.
      buzzer_q     <= (state_d == ST_RING) & beep_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beep_d       = beep_q;
    ring_cnt_d   = ring_cnt_q;
    snz_cnt_d    = snz_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    timed_out_d  = 1'b0;

    if ((state_q != ST_IDLE) && !alarm_en) begin
      // Disarming overrides everything else in an active alarm event.
      state_d      = ST_IDLE;
      snooze_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match_rise) begin
            state_d      = ST_RING;
            ring_cnt_d   = 8'd0;
            beep_d       = 1'b1;
            snooze_cnt_d = 4'd0;
          end
        end

        ST_RING: begin
          // Button edges win over a coincident tick; the tick is dropped.
          if (stop_rise) begin
            state_d      = ST_IDLE;
            snooze_cnt_d = 4'd0;
          end else if (snz_ok) begin
            state_d      = ST_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 4'd1;
            snz_cnt_d    = 16'd0;
          end else if (sec_tick) begin
            if (ring_cnt_q == RING_LAST) begin
              state_d      = ST_IDLE;
              timed_out_d  = 1'b1;
              snooze_cnt_d = 4'd0;
            end else begin
              ring_cnt_d = ring_cnt_q + 8'd1;
              beep_d     = ~beep_q;
            end
          end
        end

        ST_SNOOZE: begin
          if (stop_rise) begin
            state_d      = ST_IDLE;
            snooze_cnt_d = 4'd0;
          end else if (sec_tick) begin
            if (snz_cnt_q == SNZ_LAST) begin
              // Re-ring keeps snooze_cnt so the limit spans the whole event.
              state_d    = ST_RING;
              ring_cnt_d = 8'd0;
              beep_d     = 1'b1;
            end else begin
              snz_cnt_d = snz_cnt_q + 16'd1;
            end
          end
        end

        default: begin
          state_d      = ST_IDLE;
          snooze_cnt_d = 4'd0;
        end
      endcase
    end
  end

  assign buzzer     = buzzer_q;
  assign ringing    = (state_q == ST_RING);
  assign snoozing   = (state_q == ST_SNOOZE);
  assign snooze_cnt = snooze_cnt_q;
  assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb/tb_alarm_ring_ctrl.sv - self-checking bench for alarm_ring_ctrl

module tb_alarm_ring_ctrl;

  localparam int RS  = 4;
  localparam int SM  = 1;
  localparam int MXS = 2;

  logic       clk;
  logic       rst;
  logic       sec_tick;
  logic       alarm_en;
  logic [7:0] hr;
  logic [7:0] min;
  logic [7:0] al_hr;
  logic [7:0] al_min;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [3:0] snooze_cnt;
  logic       timed_out;

  alarm_ring_ctrl #(
    .RING_SECS (RS),
    .SNOOZE_MIN(SM),
    .MAX_SNOOZE(MXS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sec_tick  (sec_tick),
    .alarm_en  (alarm_en),
    .hr        (hr),
    .min       (min),
    .al_hr     (al_hr),
    .al_min    (al_min),
    .snooze_btn(snooze_btn),
    .stop_btn  (stop_btn),
    .buzzer    (buzzer),
    .ringing   (ringing),
    .snoozing  (snoozing),
    .snooze_cnt(snooze_cnt),
    .timed_out (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: an alarm event is either quiet, ringing (tracked as
  // seconds elapsed in this session) or snoozing (tracked as seconds left).
  localparam int QUIET = 0, RINGS = 1, DOZES = 2;
  int m_mode, m_ring_elapsed, m_doze_left, m_snoozes;
  bit m_to, m_prev_match, m_prev_snz, m_prev_stop;

  task automatic model_reset();
    m_mode = QUIET; m_ring_elapsed = 0; m_doze_left = 0; m_snoozes = 0;
    m_to = 0; m_prev_match = 0; m_prev_snz = 0; m_prev_stop = 0;
  endtask

  task automatic model_step();
    bit match_now, m_rise, s_rise, t_rise;
    if (!rst) begin
      model_reset();
      return;
    end
    match_now = alarm_en && (hr == al_hr) && (min == al_min);
    m_rise = match_now && !m_prev_match;
    s_rise = snooze_btn && !m_prev_snz;
    t_rise = stop_btn && !m_prev_stop;
    m_prev_match = match_now; m_prev_snz = snooze_btn; m_prev_stop = stop_btn;
    m_to = 0;
    if (m_mode != QUIET && !alarm_en) begin
      m_mode = QUIET; m_snoozes = 0;
    end else if (m_mode == QUIET) begin
      if (m_rise) begin m_mode = RINGS; m_ring_elapsed = 0; m_snoozes = 0; end
    end else if (m_mode == RINGS) begin
      if (t_rise) begin
        m_mode = QUIET; m_snoozes = 0;
      end else if (s_rise && m_snoozes < MXS) begin
        m_mode = DOZES; m_snoozes++; m_doze_left = SM * 60;
      end else if (sec_tick) begin
        m_ring_elapsed++;
        if (m_ring_elapsed == RS) begin m_mode = QUIET; m_to = 1; m_snoozes = 0; end
      end
    end else begin
      if (t_rise) begin
        m_mode = QUIET; m_snoozes = 0;
      end else if (sec_tick) begin
        m_doze_left--;
        if (m_doze_left == 0) begin m_mode = RINGS; m_ring_elapsed = 0; end
      end
    end
  endtask

  bit auto_tick;
  int div;
  int ticks_total;

  task automatic cycle();
    if (auto_tick) begin
      sec_tick = (div == 9);
      div = (div == 9) ? 0 : div + 1;
    end
    if (sec_tick) ticks_total++;
    @(posedge clk);
    model_step();
    #1;
    check("ringing", ringing, m_mode == RINGS);
    check("snoozing", snoozing, m_mode == DOZES);
    check("buzzer", buzzer, (m_mode == RINGS) && (m_ring_elapsed % 2 == 0));
    check("snooze_cnt", snooze_cnt, m_snoozes);
    check("timed_out", timed_out, m_to);
    if (!auto_tick) sec_tick = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic trigger();
    min = 8'd29; run(2);
    min = 8'd30; cycle();
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1; cycle();
    snooze_btn = 1'b0;
  endtask

  task automatic wait_snooze_end(input string tag);
    int t0, guard;
    t0 = ticks_total; guard = 0;
    while (snoozing && guard < 2000) begin cycle(); guard++; end
    check({tag, "_bound"}, guard < 2000, 1);
    check({tag, "_ticks"}, ticks_total - t0, 60);
    check({tag, "_rering"}, ringing, 1);
  endtask

  initial begin
    int to_pulses;
    rst = 1'b0; sec_tick = 1'b0; alarm_en = 1'b0;
    hr = 8'd7; min = 8'd29; al_hr = 8'd7; al_min = 8'd30;
    snooze_btn = 1'b0; stop_btn = 1'b0;
    auto_tick = 1; div = 0; ticks_total = 0;
    model_reset();

    #2;
    check("rst_ringing", ringing, 0);
    check("rst_snoozing", snoozing, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_cnt", snooze_cnt, 0);
    check("rst_to", timed_out, 0);
    run(2);
    rst = 1'b1;

    // Match while disarmed.
    min = 8'd30;
    for (int i = 0; i < 30; i++) begin cycle(); check("disarmed_buzz", buzzer, 0); end
    min = 8'd29; run(2);
    alarm_en = 1'b1; run(3);

    // Match and timeout.
    min = 8'd30; cycle();
    check("match_ring", ringing, 1);
    check("match_buzz", buzzer, 1);
    to_pulses = 0;
    for (int i = 0; i < 60; i++) begin cycle(); to_pulses += int'(timed_out); end
    check("timeout_pulses", to_pulses, 1);
    for (int i = 0; i < 30; i++) begin cycle(); check("no_rering", ringing, 0); end

    // Snooze limit.
    trigger(); run(3);
    press_snooze();
    check("snz1_state", snoozing, 1);
    check("snz1_cnt", snooze_cnt, 1);
    wait_snooze_end("snz1");
    run(2);
    press_snooze();
    check("snz2_state", snoozing, 1);
    check("snz2_cnt", snooze_cnt, 2);
    wait_snooze_end("snz2");
    run(2);
    press_snooze();
    check("snz3_ring", ringing, 1);
    check("snz3_cnt", snooze_cnt, 2);

    // Stop in RING, then hold.
    stop_btn = 1'b1; cycle();
    check("stop_ring_idle", ringing, 0);
    check("stop_ring_buzz", buzzer, 0);
    check("stop_ring_cnt", snooze_cnt, 0);
    for (int i = 0; i < 50; i++) begin cycle(); check("stop_hold", ringing | snoozing, 0); end
    stop_btn = 1'b0;

    // Stop in SNOOZE.
    trigger(); press_snooze(); run(5);
    stop_btn = 1'b1; cycle();
    check("stop_snz_idle", snoozing, 0);
    check("stop_snz_cnt", snooze_cnt, 0);
    check("stop_snz_buzz", buzzer, 0);
    for (int i = 0; i < 50; i++) begin cycle(); check("stop_snz_hold", ringing | snoozing, 0); end
    stop_btn = 1'b0;

    // Priority: stop + snooze edges on the final ring tick.
    auto_tick = 0; sec_tick = 1'b0;
    trigger();
    for (int k = 0; k < RS - 1; k++) begin sec_tick = 1'b1; cycle(); run(2); end
    check("prio_pre_ring", ringing, 1);
    sec_tick = 1'b1; stop_btn = 1'b1; snooze_btn = 1'b1; cycle();
    check("prio_idle", ringing | snoozing, 0);
    check("prio_to", timed_out, 0);
    check("prio_cnt", snooze_cnt, 0);
    cycle();
    check("prio_to_late", timed_out, 0);
    stop_btn = 1'b0; snooze_btn = 1'b0; auto_tick = 1; run(2);

    // Disarm mid-SNOOZE.
    trigger(); press_snooze(); run(20);
    check("dis_pre", snoozing, 1);
    alarm_en = 1'b0; cycle();
    check("dis_idle", ringing | snoozing, 0);
    check("dis_cnt", snooze_cnt, 0);
    min = 8'd29; run(2);
    alarm_en = 1'b1; run(2);

    // Asynchronous reset mid-RING.
    trigger(); run(3);
    check("arst_pre", ringing, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_ringing", ringing, 0);
    check("arst_buzzer", buzzer, 0);
    check("arst_cnt", snooze_cnt, 0);
    check("arst_to", timed_out, 0);
    model_reset();
    run(2);
    rst = 1'b1; min = 8'd29; run(2);

    // Randomized traffic against the model.
    auto_tick = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) min = (min == 8'd30) ? 8'd29 : 8'd30;
      if ($urandom_range(0, 299) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(0, 19) == 0) snooze_btn = ~snooze_btn;
      if ($urandom_range(0, 119) == 0) stop_btn = ~stop_btn;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b0;
      end else begin
        rst = 1'b1;
      end
      sec_tick = ($urandom_range(0, 3) == 0);
      cycle();
    end
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
